fifo_wr_ptr_ctrl: RTL and testbench
===================================

Name: fifo_wr_ptr_ctrl

Overview:
Write-domain pointer and flag controller for the dual-clock CORDIC FIFO. It qualifies write requests and advances the binary and Gray write pointers. The registered Gray write pointer goes to the read-domain N-stage synchronizer. The block takes the already-synchronized Gray read pointer, converts it to binary, and produces full, almost-full, fill count and overflow in the write clock domain.

Parameters:
ADDRWIDTH, 3, memory address width; depth = 2**ADDRWIDTH; pointers are ADDRWIDTH+1 bits wide.
AFULL_THRESH, 6, afull asserts when the fill count is >= this value (legal range 1..2**ADDRWIDTH).

Ports:
clk  input  1  write-domain clock; all state updates on its rising edge
srst  input  1  reset, synchronous to clk, active-high
we  input  1  write request from the producer
rd_ptr_gray_sync  input  ADDRWIDTH+1  Gray read pointer, already synchronized into clk domain
wr_en_mem  output  1  qualified RAM write strobe, combinational: we & ~full
wr_addr  output  ADDRWIDTH  RAM write address, equal to wr_ptr_bin[ADDRWIDTH-1:0]
wr_ptr_gray  output  ADDRWIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
full  output  1  registered full flag
afull  output  1  registered almost-full flag
wr_cnt  output  ADDRWIDTH+1  registered fill count as seen by the write side
overflow  output  1  registered one-cycle pulse when a write is rejected

Behaviour:
- Reset: srst high at a rising edge sets wr_ptr_bin, wr_ptr_gray, full, afull, wr_cnt and overflow to 0 on that edge. srst has priority over all other inputs. Reset mid-operation discards the pointer state. The read side is reset by the same system reset.
- Accept condition: acc = we & ~full. wr_en_mem = acc in the same cycle. wr_addr is the current wr_ptr_bin low bits.
- Pointer update: wr_bin_next = wr_ptr_bin + acc, modulo 2**(ADDRWIDTH+1). wr_ptr_bin <= wr_bin_next.
- Gray pointer: wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1). It is registered so that exactly one bit changes per accepted write; it is never a combinational output.
- Read pointer decode: rd_bin[i] = XOR of rd_ptr_gray_sync[ADDRWIDTH:i], combinational.
- Count: cnt_next = (wr_bin_next - rd_bin) mod 2**(ADDRWIDTH+1).
  - wr_cnt <= cnt_next
  - full <= (cnt_next == 2**ADDRWIDTH)
  - afull <= (cnt_next >= AFULL_THRESH)
- Latency:
  - An accepted write in cycle n is reflected in wr_ptr_gray, wr_cnt, full and afull at edge n+1.
  - A change on rd_ptr_gray_sync is reflected at the next edge.
- Back-to-back writes: sustained one write per cycle until full. The write that fills the FIFO sets full at the following edge, so the next cycle's we is rejected.
- Write while full: no RAM write and no pointer change; overflow = 1 for exactly one cycle after each rejected request.
- Simultaneous write and read-pointer advance: both are folded into cnt_next in the same cycle. Full may clear and re-set in the same edge, leaving it unchanged.
- Wrap-around: the pointer MSB toggles every 2**ADDRWIDTH writes. The subtraction stays correct across the wrap from 2**(ADDRWIDTH+1)-1 to 0.
- Pessimism: full/afull/wr_cnt lag real reads by the synchronizer depth plus one cycle. This is conservative, and overflow of the memory is impossible.
- rd_ptr_gray_sync is assumed valid Gray (one-bit changes). A non-Gray input is outside the contract and is flagged by assertion only.

Decomposition:
- Shared package / include: ptr_width = ADDRWIDTH+1 constant, plus bin2gray and gray2bin functions. The read-side controller reuses these.
- One sub-module: fifo_gray2bin, a parameterised combinational Gray-to-binary converter used for rd_ptr_gray_sync, also instantiated on the read side.

Test Plan:
1. Reset: srst=1 for 2 cycles, we=1 -> wr_en_mem=0 after the first edge; all outputs 0; wr_ptr_gray=4'h0.
2. Fill (ADDRWIDTH=3), rd_ptr_gray_sync=0, we=1 for 9 cycles:
   - wr_ptr_gray sequence 0,1,3,2,6,7,5,4,C
   - afull rises when wr_cnt=6; full=1 when wr_cnt=8
   - 9th request gives wr_en_mem=0 and overflow pulse=1 for one cycle; pointer stays 4'hC
3. Drain while full: rd_ptr_gray_sync 0 -> 4'h2 (binary 3) -> next edge wr_cnt=5, full=0, afull=0; next we accepted at wr_addr=0.
4. Simultaneous: wr_cnt=7, we=1 and rd_ptr_gray_sync advances by 1 in the same cycle -> wr_cnt stays 7, full=0.
5. Wrap-around: run writes and matched reads for 40 cycles -> wr_ptr_bin passes 15->0, wr_cnt never exceeds 8, Gray output changes one bit per write (assertion).
6. Reset mid-fill: wr_cnt=5, assert srst with we=1 -> next edge all outputs 0; no wr_en_mem while srst=1.

Source files
------------

// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// fifo_wr_ptr_ctrl_pkg: shared FIFO pointer widths and Gray/binary helpers for both clock domains
package fifo_wr_ptr_ctrl_pkg;
  localparam int DEF_ADDRWIDTH = 3;
  localparam int DEF_AFULL_THRESH = 6;
  localparam int PTR_WIDTH = DEF_ADDRWIDTH + 1;
  // Helpers work on zero-extended 32-bit values; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: parameterised combinational Gray-to-binary converter
module fifo_gray2bin
  import fifo_wr_ptr_ctrl_pkg::*;
#(
  parameter int W = PTR_WIDTH
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  assign bin = W'(gray2bin(32'(gray)));
endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-domain pointer, full/afull/count and overflow controller
module fifo_wr_ptr_ctrl
  import fifo_wr_ptr_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
  output logic                 wr_en_mem,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wr_cnt,
  output logic                 overflow
);
  localparam int PW = ADDRWIDTH + 1;
  logic [PW-1:0] wr_ptr_bin, wr_bin_next, rd_bin, cnt_next;
  logic acc;
  fifo_gray2bin #(.W(PW)) u_rd_g2b (
    .gray(rd_ptr_gray_sync),
    .bin (rd_bin)
  );
  // Reset blocks RAM writes so nothing lands in memory while pointers are being cleared.
  always_comb begin
    acc = we & ~full & ~srst;
    wr_bin_next = wr_ptr_bin + PW'(acc);
    cnt_next = wr_bin_next - rd_bin;
  end
  assign wr_en_mem = acc;
  assign wr_addr = wr_ptr_bin[ADDRWIDTH-1:0];
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_cnt      <= '0;
      full        <= 1'b0;
      afull       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr_bin  <= wr_bin_next;
      wr_ptr_gray <= PW'(bin2gray(32'(wr_bin_next)));
      wr_cnt      <= cnt_next;
      full        <= cnt_next == (PW'(1) << ADDRWIDTH);
      afull       <= cnt_next >= PW'(AFULL_THRESH);
      overflow    <= we & full;
    end
  end
  // The synchronized read pointer must move by at most one Gray step per write clock.
  a_rd_gray: assert property (@(posedge clk) disable iff (srst)
    $countones(rd_ptr_gray_sync ^ $past(rd_ptr_gray_sync)) <= 1);
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb_fifo_wr_ptr_ctrl: directed scoreboard bench for the write-side pointer controller
module tb_fifo_wr_ptr_ctrl;
  logic clk = 1'b0, srst = 1'b1, we = 1'b1;
  logic [3:0] rd_ptr_gray_sync = '0;
  logic wr_en_mem, full, afull, overflow;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray, wr_cnt;
  int checks = 0, errors = 0;
  int m_wp = 0, m_rp = 0;
  logic m_full = 1'b0;
  logic [3:0] prev_gray = '0;
  typedef struct {
    logic [3:0] gray;
    logic [3:0] cnt;
    logic full, afull, ovf, acc, rst;
  } exp_t;
  exp_t sb[$];

  fifo_wr_ptr_ctrl #(.ADDRWIDTH(3), .AFULL_THRESH(6)) dut (
    .clk(clk), .srst(srst), .we(we), .rd_ptr_gray_sync(rd_ptr_gray_sync),
    .wr_en_mem(wr_en_mem), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray),
    .full(full), .afull(afull), .wr_cnt(wr_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write-clock cycle: drive at negedge, check combinational strobe, push the
  // expected registered state, then pop and compare just after the rising edge.
  task automatic step(input logic w, input int rd_adv, input logic rst);
    exp_t e, o;
    int cnt;
    @(negedge clk);
    we = w;
    srst = rst;
    if (rst) begin
      m_wp = 0;
      m_rp = 0;
    end else m_rp += rd_adv;
    rd_ptr_gray_sync = gray4(m_rp);
    #1;
    e.rst = rst;
    e.acc = !rst && w && !m_full;
    e.ovf = !rst && w && m_full;
    chk("wr_en_mem", wr_en_mem, e.acc);
    if (e.acc) chk("wr_addr", wr_addr, 32'(m_wp % 8));
    if (e.acc) m_wp++;
    cnt = m_wp - m_rp;
    e.cnt = 4'(cnt);
    e.full = cnt == 8;
    e.afull = cnt >= 6;
    e.gray = gray4(m_wp);
    m_full = e.full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("wr_ptr_gray", wr_ptr_gray, o.gray);
    chk("wr_cnt", wr_cnt, o.cnt);
    chk("full", full, o.full);
    chk("afull", afull, o.afull);
    chk("overflow", overflow, o.ovf);
    if (!o.rst) chk("gray_step", $countones(wr_ptr_gray ^ prev_gray), o.acc ? 1 : 0);
    prev_gray = wr_ptr_gray;
  endtask

  initial begin
    // Reset with a pending write request
    step(1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1);
    chk("reset_gray", wr_ptr_gray, 4'h0);
    // Fill to full; ninth request is rejected
    for (int i = 0; i < 9; i++) step(1'b1, 0, 1'b0);
    chk("fill_gray", wr_ptr_gray, 4'hC);
    chk("fill_full", full, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("ovf_one_cycle", overflow, 1'b0);
    chk("hold_gray", wr_ptr_gray, 4'hC);
    // Read side frees three slots
    step(1'b0, 3, 1'b0);
    chk("drain_cnt", wr_cnt, 4'd5);
    step(1'b1, 0, 1'b0);
    // Write and read in the same cycle at count 7
    step(1'b1, 0, 1'b0);
    chk("pre_sim_cnt", wr_cnt, 4'd7);
    step(1'b1, 1, 1'b0);
    chk("sim_cnt", wr_cnt, 4'd7);
    chk("sim_full", full, 1'b0);
    // Sustained traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 5 != 4 && m_wp - m_rp >= 4) ? 1 : 0, 1'b0);
      chk("cnt_bound", wr_cnt <= 4'd8, 1'b1);
    end
    chk("wrapped", m_wp > 16, 1'b1);
    // Reset mid-fill at count 5
    while (m_wp - m_rp > 5) step(1'b0, 1, 1'b0);
    while (m_wp - m_rp < 5) step(1'b1, 0, 1'b0);
    chk("mid_cnt", wr_cnt, 4'd5);
    step(1'b1, 0, 1'b1);
    chk("rst_cnt", wr_cnt, 4'd0);
    step(1'b1, 0, 1'b0);
    chk("post_rst_gray", wr_ptr_gray, 4'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
